// File: rtl/run_controller.sv
// Run controller: holds a datapath in reset, releases it for a bounded run and
// stops on a pc stall (halt) or cycle budget (timeout). RUN_CTRL_STEP_EN adds single-step gating.
module run_controller #(
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 32,
    parameter int STALL_LIMIT  = 4,
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
`ifdef RUN_CTRL_STEP_EN
    input  logic                 step,
`endif
    input  logic [PC_WIDTH-1:0]  pc,
    output logic                 core_reset,
    output logic                 core_enable,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic                 halted
);

    localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                r_state;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [STALL_W-1:0]    r_stall_cnt;
    logic [PC_WIDTH-1:0]   r_last_pc;
    logic                  r_first;
    logic [CNT_WIDTH-1:0]  r_cycle_count;
    logic                  r_core_reset;
    logic                  r_core_enable;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_timeout;
    logic                  r_halted;

    state_t                w_next_state;
    logic [HOLD_W-1:0]     w_hold_cnt;
    logic [STALL_W-1:0]    w_stall_cnt;
    logic [PC_WIDTH-1:0]   w_last_pc;
    logic                  w_first;
    logic [CNT_WIDTH-1:0]  w_cycle_count;
    logic                  w_timeout;
    logic                  w_halted;
    logic                  w_core_enable;
    logic                  w_step_ok;

    // An enabled cycle is one where the datapath actually advanced (registered enable seen high).
    logic w_enabled;
    assign w_enabled = (r_state == ST_RUN) && r_core_enable;

`ifdef RUN_CTRL_STEP_EN
    assign w_step_ok = step;
`else
    assign w_step_ok = 1'b1;
`endif

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_next_state  = r_state;
        w_hold_cnt    = r_hold_cnt;
        w_stall_cnt   = r_stall_cnt;
        w_last_pc     = r_last_pc;
        w_first       = r_first;
        w_cycle_count = r_cycle_count;
        w_timeout     = r_timeout;
        w_halted      = r_halted;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next_state  = ST_HOLD;
                    w_hold_cnt    = '0;
                    w_stall_cnt   = '0;
                    w_cycle_count = '0;
                    w_timeout     = 1'b0;
                    w_halted      = 1'b0;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_next_state = ST_RUN;
                    w_first      = 1'b1;
                end else begin
                    w_hold_cnt = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (w_enabled) begin
                    w_cycle_count = r_cycle_count + CNT_WIDTH'(1);
                    if (r_first) begin
                        w_first     = 1'b0;
                        w_last_pc   = pc;
                        w_stall_cnt = '0;
                    end else if (pc == r_last_pc) begin
                        w_stall_cnt = r_stall_cnt + STALL_W'(1);
                    end else begin
                        w_stall_cnt = '0;
                        w_last_pc   = pc;
                    end
                    // Halt wins when both limits are reached on the same cycle.
                    if (w_stall_cnt == STALL_MAX) begin
                        w_next_state = ST_DONE;
                        w_halted     = 1'b1;
                    end else if (w_cycle_count == CNT_MAX) begin
                        w_next_state = ST_DONE;
                        w_timeout    = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase

        // In step mode the first RUN cycle is always idle: step is only honoured once in RUN.
`ifdef RUN_CTRL_STEP_EN
        w_core_enable = (w_next_state == ST_RUN) && (r_state == ST_RUN) && w_step_ok;
`else
        w_core_enable = (w_next_state == ST_RUN) && w_step_ok;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_last_pc     <= '0;
            r_first       <= 1'b0;
            r_cycle_count <= '0;
            r_core_reset  <= 1'b1;
            r_core_enable <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_hold_cnt    <= w_hold_cnt;
            r_stall_cnt   <= w_stall_cnt;
            r_last_pc     <= w_last_pc;
            r_first       <= w_first;
            r_cycle_count <= w_cycle_count;
            r_core_reset  <= (w_next_state == ST_IDLE) || (w_next_state == ST_HOLD);
            r_core_enable <= w_core_enable;
            r_busy        <= (w_next_state == ST_HOLD) || (w_next_state == ST_RUN);
            r_done        <= (w_next_state == ST_DONE);
            r_timeout     <= w_timeout;
            r_halted      <= w_halted;
        end
    end

    assign core_reset  = r_core_reset;
    assign core_enable = r_core_enable;
    assign cycle_count = r_cycle_count;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign halted      = r_halted;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: reset, hold release, timeout, halt, coincident
// halt/timeout, mid-run reset and (with RUN_CTRL_STEP_EN) single stepping.
module tb_run_controller;

    // Status vector order: {core_reset, core_enable, busy, done, timeout, halted}
    localparam logic [5:0] S_IDLE   = 6'b100000;
    localparam logic [5:0] S_HOLD   = 6'b101000;
    localparam logic [5:0] S_RUN    = 6'b011000;
    localparam logic [5:0] S_TMO    = 6'b000110;
    localparam logic [5:0] S_HALT   = 6'b000101;
    localparam logic [5:0] S_RUN_NE = 6'b001000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          n_vec = 0;
    int          n_miscompare = 0;

    always #5 clk = ~clk;

    // Main instance: MAX_CYCLES=32, STALL_LIMIT=4
    logic        start_a = 1'b0;
    logic [31:0] pc_a = '0;
    logic        cr_a, ce_a, busy_a, done_a, tmo_a, halt_a;
    logic [15:0] cnt_a;
    logic [5:0]  st_a;
    assign st_a = {cr_a, ce_a, busy_a, done_a, tmo_a, halt_a};

    // Coincidence instance: MAX_CYCLES=5, STALL_LIMIT=4
    logic        start_b = 1'b0;
    logic [31:0] pc_b = '0;
    logic        cr_b, ce_b, busy_b, done_b, tmo_b, halt_b;
    logic [15:0] cnt_b;
    logic [5:0]  st_b;
    assign st_b = {cr_b, ce_b, busy_b, done_b, tmo_b, halt_b};

`ifdef RUN_CTRL_STEP_EN
    logic        step_a = 1'b0;
    logic        step_b = 1'b0;
`endif

    run_controller #(
        .RESET_CYCLES(2), .MAX_CYCLES(32), .STALL_LIMIT(4), .PC_WIDTH(32), .CNT_WIDTH(16)
    ) dut_a (
        .clock(clk), .reset(reset), .start(start_a),
`ifdef RUN_CTRL_STEP_EN
        .step(step_a),
`endif
        .pc(pc_a), .core_reset(cr_a), .core_enable(ce_a), .cycle_count(cnt_a),
        .busy(busy_a), .done(done_a), .timeout(tmo_a), .halted(halt_a)
    );

    run_controller #(
        .RESET_CYCLES(2), .MAX_CYCLES(5), .STALL_LIMIT(4), .PC_WIDTH(32), .CNT_WIDTH(16)
    ) dut_b (
        .clock(clk), .reset(reset), .start(start_b),
`ifdef RUN_CTRL_STEP_EN
        .step(step_b),
`endif
        .pc(pc_b), .core_reset(cr_b), .core_enable(ce_b), .cycle_count(cnt_b),
        .busy(busy_b), .done(done_b), .timeout(tmo_b), .halted(halt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_vec++;
        if (st_a !== S_IDLE) begin
            n_miscompare++;
            $display("FAIL reset_status_a: got %b want %b", st_a, S_IDLE);
        end
        n_vec++;
        if (cnt_a !== 16'd0) begin
            n_miscompare++;
            $display("FAIL reset_count_a: got %0d want 0", cnt_a);
        end
        n_vec++;
        if (st_b !== S_IDLE) begin
            n_miscompare++;
            $display("FAIL reset_status_b: got %b want %b", st_b, S_IDLE);
        end
    endtask

    // Start pulse, two HOLD cycles, then first RUN cycle with the core enabled.
    task automatic test_hold_release();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_vec++;
        if (st_a !== S_HOLD) begin
            n_miscompare++;
            $display("FAIL hold_cycle1: got %b want %b", st_a, S_HOLD);
        end
        tick();
        n_vec++;
        if (st_a !== S_HOLD) begin
            n_miscompare++;
            $display("FAIL hold_cycle2: got %b want %b", st_a, S_HOLD);
        end
        tick();
        n_vec++;
        if (st_a !== S_RUN) begin
            n_miscompare++;
            $display("FAIL run_entry: got %b want %b", st_a, S_RUN);
        end
    endtask

    // Continues from RUN cycle 1: pc advances by 4 every cycle until the 32-cycle budget expires.
    task automatic test_timeout();
        for (int n = 1; n <= 32; n++) begin
            pc_a = 32'(4 * n);
            tick();
            if (n == 16) begin
                n_vec++;
                if (cnt_a !== 16'd16 || st_a !== S_RUN) begin
                    n_miscompare++;
                    $display("FAIL timeout_midrun: got cnt=%0d st=%b want cnt=16 st=%b", cnt_a, st_a, S_RUN);
                end
            end
        end
        n_vec++;
        if (st_a !== S_TMO) begin
            n_miscompare++;
            $display("FAIL timeout_status: got %b want %b", st_a, S_TMO);
        end
        n_vec++;
        if (cnt_a !== 16'd32) begin
            n_miscompare++;
            $display("FAIL timeout_count: got %0d want 32", cnt_a);
        end
        tick();
        tick();
        n_vec++;
        if (cnt_a !== 16'd32 || st_a !== S_TMO) begin
            n_miscompare++;
            $display("FAIL done_frozen: got cnt=%0d st=%b want cnt=32 st=%b", cnt_a, st_a, S_TMO);
        end
    endtask

    // Restart from DONE; start held high through HOLD and part of RUN must be ignored.
    task automatic test_halt();
        start_a = 1'b1;
        tick();
        n_vec++;
        if (st_a !== S_HOLD || cnt_a !== 16'd0) begin
            n_miscompare++;
            $display("FAIL restart_clear: got cnt=%0d st=%b want cnt=0 st=%b", cnt_a, st_a, S_HOLD);
        end
        tick();
        tick();
        n_vec++;
        if (st_a !== S_RUN) begin
            n_miscompare++;
            $display("FAIL restart_run_entry: got %b want %b", st_a, S_RUN);
        end
        for (int n = 1; n <= 14; n++) begin
            pc_a = (n < 10) ? 32'(4 * n) : 32'h40;
            if (n == 6) start_a = 1'b0;
            tick();
            if (n == 5) begin
                n_vec++;
                if (cnt_a !== 16'd5 || st_a !== S_RUN) begin
                    n_miscompare++;
                    $display("FAIL start_ignored_run: got cnt=%0d st=%b want cnt=5 st=%b", cnt_a, st_a, S_RUN);
                end
            end
            if (n == 13) begin
                n_vec++;
                if (st_a !== S_RUN) begin
                    n_miscompare++;
                    $display("FAIL halt_not_early: got %b want %b", st_a, S_RUN);
                end
            end
        end
        n_vec++;
        if (st_a !== S_HALT) begin
            n_miscompare++;
            $display("FAIL halt_status: got %b want %b", st_a, S_HALT);
        end
        n_vec++;
        if (cnt_a !== 16'd14) begin
            n_miscompare++;
            $display("FAIL halt_count: got %0d want 14", cnt_a);
        end
    endtask

    // Halt and timeout land on the same edge at count 5; halt must win.
    task automatic test_coincide();
        pc_b = 32'h100;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        tick();
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (n == 4) begin
                n_vec++;
                if (st_b !== S_RUN || cnt_b !== 16'd4) begin
                    n_miscompare++;
                    $display("FAIL coincide_pre: got cnt=%0d st=%b want cnt=4 st=%b", cnt_b, st_b, S_RUN);
                end
            end
        end
        n_vec++;
        if (st_b !== S_HALT) begin
            n_miscompare++;
            $display("FAIL coincide_status: got %b want %b", st_b, S_HALT);
        end
        n_vec++;
        if (cnt_b !== 16'd5) begin
            n_miscompare++;
            $display("FAIL coincide_count: got %0d want 5", cnt_b);
        end
    endtask

    // Reset asserted during RUN cycle 7 together with start; reset must win.
    task automatic test_reset_mid_run();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        for (int n = 1; n <= 6; n++) begin
            pc_a = 32'(8 * n);
            tick();
        end
        n_vec++;
        if (cnt_a !== 16'd6 || st_a !== S_RUN) begin
            n_miscompare++;
            $display("FAIL midrun_pre: got cnt=%0d st=%b want cnt=6 st=%b", cnt_a, st_a, S_RUN);
        end
        reset = 1'b1;
        start_a = 1'b1;
        tick();
        reset = 1'b0;
        start_a = 1'b0;
        n_vec++;
        if (st_a !== S_IDLE || cnt_a !== 16'd0) begin
            n_miscompare++;
            $display("FAIL midrun_reset: got cnt=%0d st=%b want cnt=0 st=%b", cnt_a, st_a, S_IDLE);
        end
        for (int n = 0; n < 5; n++) tick();
        n_vec++;
        if (st_a !== S_IDLE) begin
            n_miscompare++;
            $display("FAIL stays_idle: got %b want %b", st_a, S_IDLE);
        end
    endtask

`ifdef RUN_CTRL_STEP_EN
    // Step sampled in RUN cycles 2, 5, 8 enables the following cycles 3, 6, 9.
    task automatic test_step();
        int pulses;
        pulses = 0;
        pc_a = 32'h200;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        step_a = 1'b1;
        tick();
        tick();
        n_vec++;
        if (st_a !== S_RUN_NE) begin
            n_miscompare++;
            $display("FAIL step_run_entry: got %b want %b", st_a, S_RUN_NE);
        end
        for (int c = 1; c <= 10; c++) begin
            step_a = (c == 2 || c == 5 || c == 8);
            tick();
            if (ce_a) pulses++;
        end
        step_a = 1'b0;
        n_vec++;
        if (pulses !== 3) begin
            n_miscompare++;
            $display("FAIL step_pulses: got %0d want 3", pulses);
        end
        n_vec++;
        if (cnt_a !== 16'd3 || busy_a !== 1'b1) begin
            n_miscompare++;
            $display("FAIL step_count: got cnt=%0d busy=%b want cnt=3 busy=1", cnt_a, busy_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_hold_release();
        test_timeout();
        test_halt();
        test_coincide();
        test_reset_mid_run();
`ifdef RUN_CTRL_STEP_EN
        test_step();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
